// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 2**ADDR_W x DATA_W register file with bypassed reads, commit trace and retire counter
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemToReg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [CNT_W-1:0]  retire_cnt
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic              we;
  assign wb_data = MemToReg ? mem_data : alu_out;
  assign we      = RegWrite && (rd != '0);
  // index 0 reads as zero even when it matches rd, so the bypass never exposes a dropped write
  assign rs_data = (rs_addr == '0) ? '0 : (we && rs_addr == rd) ? wb_data : regs[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 : (we && rt_addr == rd) ? wb_data : regs[rt_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      retire_cnt   <= '0;
    end else begin
      commit_valid <= we;
      if (we) begin
        regs[rd]    <= wb_data;
        commit_rd   <= rd;
        commit_data <= wb_data;
        retire_cnt  <= retire_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
- Selects the write-back value (memory load data or ALU result) and commits it to the 32 x 32-bit general-purpose register file.
- Serves the two ID-stage read ports with a same-cycle write-to-read bypass.
- Provides a registered commit trace and a retire counter for the verification environment.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; the file holds 2**ADDR_W entries.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- RegWrite  input  1  write-back enable from MEM/WB.
- MemToReg  input  1  1 = write mem_data, 0 = write alu_out.
- mem_data  input  DATA_W  load data from MEM/WB.
- alu_out  input  DATA_W  ALU result from MEM/WB.
- rd  input  ADDR_W  destination register index from MEM/WB.
- rs_addr  input  ADDR_W  ID-stage read port A index.
- rt_addr  input  ADDR_W  ID-stage read port B index.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- wb_data  output  DATA_W  combinational selected write-back value, to the EX forwarding mux.
- commit_valid  output  1  registered: a register write committed last cycle.
- commit_rd  output  ADDR_W  registered index of the last commit.
- commit_data  output  DATA_W  registered value of the last commit.
- retire_cnt  output  CNT_W  number of committed register writes since reset.

Behaviour:
- Reset is synchronous and active-high. Only clk and rst are clock/reset ports.
- Write-back select:
  - wb_data = MemToReg ? mem_data : alu_out, purely combinational.
  - wb_data is independent of RegWrite.
- Commit condition: we = RegWrite && (rd != 0).
- On a rising edge with we=1, regs[rd] <= wb_data. Latency: the value is architecturally visible from the next cycle, and the bypass makes it visible in the same cycle.
- Register 0:
  - It is never written; writes to it are dropped silently.
  - Reads of index 0 always return 0, including when the bypass conditions match.
- Read ports:
  - rs_data = (rs_addr==0) ? 0 : (we && rs_addr==rd) ? wb_data : regs[rs_addr]. rt_data uses the same rule.
  - Both ports may read the same index. Both may match rd simultaneously, and both then get wb_data.
- Commit trace, on every non-reset edge:
  - commit_valid <= we.
  - commit_rd <= we ? rd : commit_rd.
  - commit_data <= we ? wb_data : commit_data. The rd and data fields hold when no commit occurs.
- Retire counter: retire_cnt <= retire_cnt + 1 on each edge with we=1. It wraps modulo 2**CNT_W with no saturation and no flag.
- Reset, when rst=1 at an edge:
  - All 2**ADDR_W registers are cleared to 0.
  - commit_valid=0, commit_rd=0, commit_data=0, retire_cnt=0.
  - Any write presented in that cycle is discarded. Reset has priority over write.
- Read ports during a reset cycle:
  - rs_data and rt_data follow the combinational rule. The bypass is still active if RegWrite is high.
  - The bench checks read data only from the cycle after rst deasserts; all reads then return 0 until written.
- X-safety: RegWrite=0 with X on rd, mem_data or alu_out must not alter any state.
- Implementation: no other state is permitted. The register array is inferred as flops, not block RAM, because of the synchronous whole-file clear.

Test Plan:
- Reset then read: hold rst 1 cycle, release, sweep rs_addr/rt_addr over 0..31 -> every read returns 0x00000000; retire_cnt=0; commit_valid=0.
- ALU and load write-back:
  - Write rd=5, MemToReg=0, alu_out=0x1234_5678, and the next cycle rd=6, MemToReg=1, mem_data=0xDEAD_BEEF.
  - Required: regs 5 and 6 read back those values; retire_cnt=2; commit_rd/commit_data track each write one cycle later.
- Same-cycle bypass: RegWrite=1, rd=9, alu_out=0xCAFE_0001, rs_addr=rt_addr=9 in the same cycle -> rs_data=rt_data=0xCAFE_0001 combinationally, before the edge.
- $zero protection: RegWrite=1, rd=0, alu_out=0xFFFF_FFFF, rs_addr=0 -> rs_data=0 in that cycle and after; commit_valid=0; retire_cnt unchanged.
- Reset mid-operation: regs 1..3 hold nonzero values; assert rst in the same cycle as a write rd=4, data 0x55 -> next cycle regs 1..4 read 0, retire_cnt=0, commit_valid=0.
- Disabled write and counter wrap:
  - RegWrite=0 with rd=7, data 0xAA -> reg 7 is unchanged and the counter holds.
  - With CNT_W=4, perform 17 commits -> retire_cnt=1.
